video_mem: RTL and testbench

Parametrised simple-dual-port synchronous memory for the VGA datapath, serving palettes and small frame or tile buffers. It replaces the single bidirectional-bus memory with separate write and read ports, a write handshake, a configurable read pipeline and a built-in clear engine. It sits between the pixel-producing logic (write side) and the VGA scan-out logic (read side), all in one clock domain.

---
 rtl/video_mem_pkg.sv | 12 +
 rtl/video_mem_clear_fsm.sv | 55 +++++
 rtl/video_mem.sv | 92 +++++++++
 tb/tb_video_mem.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/video_mem_pkg.sv
// Shared types and constants for the video_mem simple-dual-port memory.
package video_mem_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/video_mem_clear_fsm.sv
// Clear engine: walks addresses 0..DEPTH-1 issuing one clear write per cycle.
module video_mem_clear_fsm
   import video_mem_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_req,
   output logic                  clear_busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            addr_d = '0;
            if (clear_req) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign clear_busy = (state_q == ST_CLEAR);
   assign clr_we     = (state_q == ST_CLEAR);
   assign clr_addr   = addr_q;

endmodule

// File: rtl/video_mem.sv
// Simple-dual-port VGA memory with write handshake, 1/2-cycle read pipeline and clear engine.
module video_mem
   import video_mem_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH  = 12,
   parameter int unsigned          DEPTH       = 16,
   parameter int unsigned          ADDR_WIDTH  = $clog2(DEPTH),
   parameter int unsigned          RD_LATENCY  = 1,
   parameter string                INIT_FILE   = "",
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  clear_req,
   output logic                  clear_busy
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  rd_valid1_q;
   logic [DATA_WIDTH-1:0] rd_data1_q;

   video_mem_clear_fsm #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_fsm (
      .clk        (clk),
      .rst        (rst),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .clr_we     (clr_we),
      .clr_addr   (clr_addr)
   );

   assign wr_ready = !clear_busy;

   // Clear writes own the port while busy; out-of-range user writes are dropped.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= CLEAR_VALUE;
      end else if (wr_valid && wr_ready && (32'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid1_q <= 1'b0;
         rd_data1_q  <= '0;
      end else begin
         rd_valid1_q <= rd_en;
         if (rd_en) rd_data1_q <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
      end
   end

   generate
      if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
         $error("video_mem: RD_LATENCY must be 1 or 2");
      end else if (RD_LATENCY == 2) begin : g_lat2
         logic                  rd_valid2_q;
         logic [DATA_WIDTH-1:0] rd_data2_q;

         // Output register stage; data holds while no result is presented.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_valid2_q <= 1'b0;
               rd_data2_q  <= '0;
            end else begin
               rd_valid2_q <= rd_valid1_q;
               if (rd_valid1_q) rd_data2_q <= rd_data1_q;
            end
         end

         assign rd_valid = rd_valid2_q;
         assign rd_data  = rd_data2_q;
      end else begin : g_lat1
         assign rd_valid = rd_valid1_q;
         assign rd_data  = rd_data1_q;
      end
   endgenerate

endmodule

// File: tb/tb_video_mem.sv
// Scoreboard bench for video_mem: DUT A (16 deep, latency 1), DUT B (12 deep, latency 2).
module tb_video_mem;

   typedef struct {
      logic [11:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   logic        rst_a, wr_valid_a, wr_ready_a, rd_en_a, rd_valid_a, clear_req_a, clear_busy_a;
   logic [3:0]  wr_addr_a, rd_addr_a;
   logic [11:0] wr_data_a, rd_data_a;

   logic        rst_b, wr_valid_b, wr_ready_b, rd_en_b, rd_valid_b, clear_req_b, clear_busy_b;
   logic [3:0]  wr_addr_b, rd_addr_b;
   logic [11:0] wr_data_b, rd_data_b;

   video_mem #(
      .DATA_WIDTH (12), .DEPTH (16), .RD_LATENCY (1), .CLEAR_VALUE (12'h123)
   ) dut_a (
      .clk (clk), .rst (rst_a),
      .wr_valid (wr_valid_a), .wr_ready (wr_ready_a), .wr_addr (wr_addr_a), .wr_data (wr_data_a),
      .rd_en (rd_en_a), .rd_addr (rd_addr_a), .rd_valid (rd_valid_a), .rd_data (rd_data_a),
      .clear_req (clear_req_a), .clear_busy (clear_busy_a)
   );

   video_mem #(
      .DATA_WIDTH (12), .DEPTH (12), .RD_LATENCY (2)
   ) dut_b (
      .clk (clk), .rst (rst_b),
      .wr_valid (wr_valid_b), .wr_ready (wr_ready_b), .wr_addr (wr_addr_b), .wr_data (wr_data_b),
      .rd_en (rd_en_b), .rd_addr (rd_addr_b), .rd_valid (rd_valid_b), .rd_data (rd_data_b),
      .clear_req (clear_req_b), .clear_busy (clear_busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop one expectation per presented read result, checking data and arrival cycle.
   always @(negedge clk) begin
      if (rd_valid_a === 1'b1) begin
         exp_t e;
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL rd_a_unexpected: got data 0x%0h with no pending read (cycle %0d)", rd_data_a, cyc);
         end else begin
            e = q_a.pop_front();
            if (rd_data_a !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL rd_a: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                        rd_data_a, cyc, e.data, e.cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rd_valid_b === 1'b1) begin
         exp_t e;
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL rd_b_unexpected: got data 0x%0h with no pending read (cycle %0d)", rd_data_b, cyc);
         end else begin
            e = q_b.pop_front();
            if (rd_data_b !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL rd_b: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                        rd_data_b, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic push(input bit b, input logic [11:0] d);
      if (!b) q_a.push_back('{d, cyc + 1});
      else    q_b.push_back('{d, cyc + 2});
   endtask

   task automatic wr(input bit b, input logic [3:0] a, input logic [11:0] d);
      if (!b) begin wr_valid_a = 1'b1; wr_addr_a = a; wr_data_a = d; end
      else    begin wr_valid_b = 1'b1; wr_addr_b = a; wr_data_b = d; end
      @(negedge clk);
      wr_valid_a = 1'b0;
      wr_valid_b = 1'b0;
   endtask

   task automatic rd(input bit b, input logic [3:0] a, input logic [11:0] d);
      if (!b) begin rd_en_a = 1'b1; rd_addr_a = a; end
      else    begin rd_en_b = 1'b1; rd_addr_b = a; end
      push(b, d);
      @(negedge clk);
      rd_en_a = 1'b0;
      rd_en_b = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (q_a.size() == 0 && q_b.size() == 0) break;
         @(negedge clk);
      end
      chk("queue_a_drained", q_a.size(), 0);
      chk("queue_b_drained", q_b.size(), 0);
   endtask

   initial begin
      int busy;
      rst_a = 1'b1; wr_valid_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
      rd_en_a = 1'b0; rd_addr_a = '0; clear_req_a = 1'b0;
      rst_b = 1'b1; wr_valid_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
      rd_en_b = 1'b0; rd_addr_b = '0; clear_req_b = 1'b0;
      repeat (2) @(negedge clk);

      chk("reset_rd_valid_a", rd_valid_a, 0);
      chk("reset_rd_data_a", rd_data_a, 0);
      chk("reset_clear_busy_a", clear_busy_a, 0);
      chk("reset_wr_ready_a", wr_ready_a, 1);
      chk("reset_rd_valid_b", rd_valid_b, 0);
      chk("reset_rd_data_b", rd_data_b, 0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);

      // Load identity pattern and read it back with back-to-back reads.
      for (int a = 0; a < 16; a++) wr(0, 4'(a), 12'(a));
      for (int a = 0; a < 16; a++) rd(0, 4'(a), 12'(a));

      // Same-cycle read/write is read-first, next-cycle read sees the new word.
      wr_valid_a = 1'b1; wr_addr_a = 4'hA; wr_data_a = 12'h83D;
      rd_en_a = 1'b1; rd_addr_a = 4'hA; push(0, 12'h00A);
      @(negedge clk);
      wr_valid_a = 1'b0; rd_en_a = 1'b0;
      rd(0, 4'hA, 12'h83D);

      // Full clear with a blocked write and an in-flight read.
      for (int a = 0; a < 16; a++) wr(0, 4'(a), 12'hFFF);
      clear_req_a = 1'b1;
      @(negedge clk);
      clear_req_a = 1'b0;
      busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (clear_busy_a !== 1'b1) break;
         chk("wr_ready_low_in_clear", wr_ready_a, 0);
         if (i == 0) begin rd_en_a = 1'b1; rd_addr_a = 4'd15; push(0, 12'hFFF); end
         if (i == 6) begin wr_valid_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 12'h555; end
         busy++;
         @(negedge clk);
         rd_en_a = 1'b0;
         wr_valid_a = 1'b0;
      end
      chk("clear_busy_cycles", busy, 16);
      chk("wr_ready_after_clear", wr_ready_a, 1);
      for (int a = 0; a < 16; a++) rd(0, 4'(a), 12'h123);

      // Reset after addresses 0..4 are cleared aborts the clear.
      for (int a = 0; a < 16; a++) wr(0, 4'(a), 12'hFFF);
      clear_req_a = 1'b1;
      @(negedge clk);
      clear_req_a = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) begin rd_en_a = 1'b1; rd_addr_a = 4'd0; push(0, 12'h123); end
         @(negedge clk);
         rd_en_a = 1'b0;
      end
      chk("clear_busy_before_rst", clear_busy_a, 1);
      #2 rst_a = 1'b1;
      #1;
      chk("rst_mid_clear_busy", clear_busy_a, 0);
      chk("rst_mid_clear_rd_valid", rd_valid_a, 0);
      chk("rst_mid_clear_wr_ready", wr_ready_a, 1);
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      chk("no_resume_after_rst", clear_busy_a, 0);
      for (int a = 0; a < 16; a++) rd(0, 4'(a), (a < 5) ? 12'h123 : 12'hFFF);

      // DUT B: out-of-range write dropped, out-of-range read returns 0, latency-2 stream.
      wr(1, 4'd13, 12'hABC);
      for (int a = 0; a < 12; a++) wr(1, 4'(a), 12'(12'h100 + a));
      rd(1, 4'd13, 12'h000);
      for (int a = 0; a < 12; a++) rd(1, 4'(a), 12'(12'h100 + a));
      drain();
      repeat (3) @(negedge clk);
      chk("rd_data_b_holds", rd_data_b, 12'h10B);
      chk("rd_valid_b_idle", rd_valid_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
